// File: rtl/jt51_slot_pkg.sv
// Shared widths, field indices, slot packing helper and write-entry layout
// for the jt51 slot scheduler.
package jt51_slot_pkg;
  localparam int CH_W_D   = 3;
  localparam int OP_W_D   = 2;
  localparam int DW_D     = 8;
  localparam int NFLD_D   = 4;
  localparam int QDEPTH_D = 2;

  typedef enum logic [1:0] {
    FLD_DT1MUL = 2'd0,
    FLD_TL     = 2'd1,
    FLD_KSAR   = 2'd2,
    FLD_D1LRR  = 2'd3
  } fld_e;

  typedef struct packed {
    logic [OP_W_D-1:0] op;
    logic [CH_W_D-1:0] ch;
    logic [1:0]        fld;
    logic [DW_D-1:0]   data;
  } wr_entry_t;

  function automatic int slot_idx(input int op, input int ch, input int ch_w);
    return (op << ch_w) | ch;
  endfunction
endpackage

// File: rtl/jt51_slot_fifo.sv
// Synchronous FIFO with clock enable and a registered full flag, so ready
// never depends combinationally on a same-cycle pop.
module jt51_slot_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
)(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cen,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_rd, r_wr;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic                    r_full;
  logic                    w_do_push, w_do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_push = i_cen & i_push & ~r_full;
  assign w_do_pop  = i_cen & i_pop & (r_cnt != '0);
  assign w_cnt_nxt = r_cnt + CW'(w_do_push) - CW'(w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem  <= '0;
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= inc(r_wr);
      end
      if (w_do_pop) r_rd <= inc(r_rd);
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == CW'(DEPTH));
    end
  end

  assign o_full  = r_full;
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/jt51_slot_sched.sv
// Slot sequencer plus queued per-slot register store; writes land only as the
// counter passes their slot. Optional readback port: JT51_SLOT_RDBACK_EN.
module jt51_slot_sched import jt51_slot_pkg::*; #(
  parameter  int CH_W   = CH_W_D,
  parameter  int OP_W   = OP_W_D,
  parameter  int DW     = DW_D,
  parameter  int NFLD   = NFLD_D,
  parameter  int QDEPTH = QDEPTH_D,
  localparam int SW     = CH_W + OP_W,
  localparam int NSLOT  = 1 << SW,
  localparam int FW     = (NFLD > 1) ? $clog2(NFLD) : 1
)(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cen,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [OP_W-1:0]    i_wr_op,
  input  logic [CH_W-1:0]    i_wr_ch,
  input  logic [FW-1:0]      i_wr_fld,
  input  logic [DW-1:0]      i_wr_data,
  output logic               o_wr_done,
  output logic [SW-1:0]      o_slot,
  output logic [OP_W-1:0]    o_cur_op,
  output logic [CH_W-1:0]    o_cur_ch,
  output logic               o_zero,
  output logic               o_half,
  output logic [SW-1:0]      o_rd_slot,
  output logic [NFLD*DW-1:0] o_rd_data
`ifdef JT51_SLOT_RDBACK_EN
  ,
  input  logic               i_rb_req,
  input  logic [OP_W-1:0]    i_rb_op,
  input  logic [CH_W-1:0]    i_rb_ch,
  input  logic [FW-1:0]      i_rb_fld,
  output logic [DW-1:0]      o_rb_data,
  output logic               o_rb_valid
`endif
);
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [CH_W-1:0] ch;
    logic [FW-1:0]   fld;
    logic [DW-1:0]   data;
  } ent_t;

  ent_t                          w_push_ent, w_head;
  logic                          w_full, w_empty, w_commit;
  logic [SW-1:0]                 r_slot, w_next, w_head_slot;
  logic                          r_zero, r_half, r_wr_done;
  logic [SW-1:0]                 r_rd_slot;
  logic [NFLD*DW-1:0]            r_rd_data, w_rd_word;
  logic [NSLOT-1:0][NFLD*DW-1:0] r_mem;

  assign w_push_ent  = {i_wr_op, i_wr_ch, i_wr_fld, i_wr_data};
  assign w_next      = r_slot + 1'b1;
  assign w_head_slot = SW'(slot_idx(int'(w_head.op), int'(w_head.ch), CH_W));
  assign w_commit    = ~w_empty & (r_slot == w_head_slot);

  jt51_slot_fifo #(.W($bits(ent_t)), .DEPTH(QDEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_cen  (i_cen),
    .i_push (i_wr_valid),
    .i_data (w_push_ent),
    .i_pop  (w_commit),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (w_head)
  );

  // Write-first view of the current slot; also the value stored on commit.
  always_comb begin
    w_rd_word = r_mem[r_slot];
    if (w_commit) w_rd_word[w_head.fld*DW +: DW] = w_head.data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot    <= '0;
      r_zero    <= 1'b0;
      r_half    <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_slot <= '0;
      r_rd_data <= '0;
      r_mem     <= '0;
    end else begin
      r_wr_done <= 1'b0;
      if (i_cen) begin
        r_slot    <= w_next;
        r_zero    <= (w_next == '0);
        r_half    <= (w_next[SW-2:0] == '0);
        r_wr_done <= w_commit;
        r_rd_slot <= r_slot;
        r_rd_data <= w_rd_word;
        if (w_commit) r_mem[r_slot] <= w_rd_word;
      end
    end
  end

  assign o_wr_ready = ~w_full;
  assign o_wr_done  = r_wr_done;
  assign o_slot     = r_slot;
  assign o_cur_op   = r_slot[SW-1:CH_W];
  assign o_cur_ch   = r_slot[CH_W-1:0];
  assign o_zero     = r_zero;
  assign o_half     = r_half;
  assign o_rd_slot  = r_rd_slot;
  assign o_rd_data  = r_rd_data;

`ifdef JT51_SLOT_RDBACK_EN
  logic          r_rb_pend, r_rb_valid;
  logic [SW-1:0] r_rb_slot;
  logic [FW-1:0] r_rb_fld;
  logic [DW-1:0] r_rb_data;
  logic          w_rb_hit;

  assign w_rb_hit = r_rb_pend & (r_slot == r_rb_slot);

  // One outstanding read; it resolves on the same slot pass rule as commits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rb_pend  <= 1'b0;
      r_rb_valid <= 1'b0;
      r_rb_slot  <= '0;
      r_rb_fld   <= '0;
      r_rb_data  <= '0;
    end else begin
      r_rb_valid <= 1'b0;
      if (i_cen) begin
        if (w_rb_hit) begin
          r_rb_data  <= w_rd_word[r_rb_fld*DW +: DW];
          r_rb_valid <= 1'b1;
          r_rb_pend  <= 1'b0;
        end else if (i_rb_req && !r_rb_pend) begin
          r_rb_slot <= {i_rb_op, i_rb_ch};
          r_rb_fld  <= i_rb_fld;
          r_rb_pend <= 1'b1;
        end
      end
    end
  end

  assign o_rb_data  = r_rb_data;
  assign o_rb_valid = r_rb_valid;
`endif
endmodule

// File: doc/jt51_slot_sched.md
Name: jt51_slot_sched

Overview:
- Parametrised slot sequencer and per-operator register scheduler; successor to the fixed 32-slot (4 op × 8 ch) register block.
- Generates the slot counter and pipeline marker flags.
- Buffers host register writes in a small FIFO. Each write commits only when the slot counter passes the target slot, emulating shift-register storage.
- Presents per-slot field data to the operator/envelope pipeline. Sits between the host write decoder and the pipeline.

Parameters:
- CH_W, 3, channel index width; channel count = 2^CH_W.
- OP_W, 2, operator index width.
- DW, 8, field data width.
- NFLD, 4, number of DW-bit fields stored per slot.
- QDEPTH, 2, write FIFO depth (≥1).
- Derived: SW = CH_W+OP_W; NSLOT = 2^SW; FW = max(1, clog2(NFLD)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cen  in  1  clock enable; all state advances only when cen=1.
- wr_valid  in  1  host write request.
- wr_ready  out  1  FIFO not full.
- wr_op  in  OP_W  target operator.
- wr_ch  in  CH_W  target channel.
- wr_fld  in  FW  target field.
- wr_data  in  DW  field value.
- wr_done  out  1  one-cen pulse when a write has committed.
- slot  out  SW  current slot counter {op,ch}.
- cur_op  out  OP_W  slot[SW-1:CH_W].
- cur_ch  out  CH_W  slot[CH_W-1:0].
- zero  out  1  next slot == 0.
- half  out  1  next slot low SW-1 bits == 0.
- rd_slot  out  SW  slot tagged to rd_data.
- rd_data  out  NFLD*DW  all fields of rd_slot; field f is at [f*DW +: DW].

Behaviour:
- Reset (rst=1 at posedge clk, regardless of cen):
  - slot=0, zero=0, half=0, rd_slot=0, rd_data=0, wr_done=0.
  - FIFO emptied, so wr_ready=1. All storage cleared to 0.
  - A write pending at reset is discarded with no wr_done.
- Counter, per cen:
  - slot<=slot+1, wrapping NSLOT-1→0.
  - zero<=(next==0); half<=(next[SW-2:0]==0).
  - Default config: zero is high for 1 of 32 slots, half for 2 of 32.
- FIFO push: on cen with wr_valid && wr_ready, {wr_op,wr_ch,wr_fld,wr_data} is enqueued.
- Backpressure:
  - wr_ready = !full, registered from occupancy. There is no same-cycle bypass.
  - When full, a simultaneous pop does not raise ready until the next cycle.
  - wr_valid while !wr_ready is ignored; the host holds it.
- Commit (head entry, on cen):
  - Condition: FIFO non-empty and slot == {head.op, head.ch}.
  - Action: mem[slot][head.fld] <= head.data, pop the head, wr_done<=1 for that cen.
  - At most one commit per cen. Entries commit strictly in FIFO order; a later entry for an earlier-passing slot waits.
  - Worst-case latency from push to commit is QDEPTH×NSLOT cen ticks.
- Readout, per cen:
  - rd_slot<=slot; rd_data<=mem[slot] with write-first forwarding, so a commit in the same cen is visible immediately.
  - rd_data is therefore one cen behind slot.
- Simultaneous push and commit: both happen and occupancy is unchanged. A push into an empty FIFO cannot commit in the same cen.
- Two writes to the same slot/field: the later one wins.
- cen=0: nothing changes, and wr_done is held low.

Optional Feature:
- Macro: JT51_SLOT_RDBACK_EN.
- With the macro defined:
  - Adds ports rb_req (in, 1), rb_op, rb_ch, rb_fld (in), rb_data (out, DW), rb_valid (out, 1).
  - The read is captured on cen when rb_req=1.
  - rb_data is returned when slot matches, with the same timing rule as commit.
  - rb_valid pulses for one cen.
  - It reflects any commit in the same cen.
  - A new rb_req while a readback is pending is ignored.
- Without the macro: these ports and their logic are absent.

Decomposition:
- Package jt51_slot_pkg:
  - Default widths.
  - Field index constants FLD_DT1MUL=0, FLD_TL=1, FLD_KSAR=2, FLD_D1LRR=3.
  - A slot-index packing function {op,ch}.
  - Write-entry struct typedef.
- Sub-module jt51_slot_fifo: parametrised synchronous FIFO (depth QDEPTH, with cen, registered full flag) used for the write queue.

Test Plan:
- Reset mid-run: push a write, assert rst at slot 5 → slot=0, rd_data=0, wr_ready=1, and no wr_done for the dropped write.
- Single write: at slot=3 push op=1, ch=2, fld=1, data=8'h5A → commit at slot 10; wr_done pulses once; in the same cen rd_slot=10 and rd_data[15:8]=5A; rd_data[15:8]=5A again when rd_slot=10 32 cen later.
- Backpressure: push writes to slots 31 and 30 back-to-back from slot 0 → wr_ready=0. Third push is held; slot 31 commits first, then slot 30 a further 31 ticks later; ordering is preserved.
- Overwrite: two queued writes to slot 7 fld 0 with 11 then 22 → the final stored value is 22, with two wr_done pulses on successive passes of slot 7.
- Flags and cen gating: drive cen at 1-in-3 → slot advances only on cen; zero high only when next=0; half high at next=0 and next=16; wr_done pulses are never wider than one cen cycle.
- (JT51_SLOT_RDBACK_EN) readback of slot 10 fld 1 after the single-write case → rb_valid when slot=10, rb_data=8'h5A.
